aes_round_sched: RTL and testbench

- Iterative AES-128 encryption round scheduler. Owns the 128-bit state register and the round-key register, and sequences one round per clock through an external combinational round datapath (SubBytes, ShiftRow, MixColumns, AddRoundKey) and an external key-expansion step.
- Generates the round number, the Rcon byte and the last-round flag that tells the datapath to bypass MixColumns.
- Accepts blocks through a valid/ready input port and returns ciphertext through a valid/ready output port.
- Sits between the top-level AES wrapper and the round datapath.

---
 rtl/aes_round_sched.sv | 114 +++++++++++
 tb/tb_aes_round_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sched.sv
// Iterative AES-128 round scheduler. Owns the state and round-key registers and
// steps an external round datapath and key expansion through NR rounds per block.
module aes_round_sched #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  input  logic [127:0]  in_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  input  logic          abort,
  output logic [127:0]  round_state,
  output logic [127:0]  round_key,
  output logic [7:0]    rcon,
  output logic [RW-1:0] round_num,
  output logic          last_round,
  input  logic [127:0]  dp_state,
  input  logic [127:0]  dp_key,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [127:0]  state_q, state_d;
  logic [127:0]  key_q, key_d;
  logic [RW-1:0] round_q, round_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          at_last;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign at_last = (round_q == RW'(NR));

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned and infers a latch.
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    if (abort) begin
      // Flush keeps the data registers; only control returns to idle.
      fsm_d   = IDLE;
      round_d = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_d = in_data ^ in_key;
            key_d   = in_key;
            round_d = RW'(1);
            rcon_d  = 8'h01;
            fsm_d   = ROUND;
          end
        end
        ROUND: begin
          state_d = dp_state;
          key_d   = dp_key;
          if (at_last) begin
            fsm_d = DONE;
          end else begin
            round_d = round_q + RW'(1);
            rcon_d  = xtime(rcon_q);
          end
        end
        DONE: begin
          if (out_ready) fsm_d = IDLE;
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  assign in_ready    = (fsm_q == IDLE);
  assign out_valid   = (fsm_q == DONE);
  assign busy        = (fsm_q == ROUND);
  assign out_data    = state_q;
  assign round_state = state_q;
  assign round_key   = key_q;
  assign rcon        = rcon_q;
  assign round_num   = round_q;
  // Gated by ROUND: the counter holds NR through DONE, but MixColumns bypass only matters while rounds run.
  assign last_round  = busy && at_last;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: models the external AES round datapath and key
// expansion, and checks FIPS-197 ciphertexts plus scheduler control behaviour.
module tb_aes_round_sched;

  localparam int NR = 10;
  localparam int RW = 4;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic [127:0]  in_key;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic          abort;
  logic [127:0]  round_state;
  logic [127:0]  round_key;
  logic [7:0]    rcon;
  logic [RW-1:0] round_num;
  logic          last_round;
  logic [127:0]  dp_state;
  logic [127:0]  dp_key;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rcon_exp [NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes_round_sched #(.NR(NR), .RW(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_key     (in_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .abort      (abort),
    .round_state(round_state),
    .round_key  (round_key),
    .rcon       (rcon),
    .round_num  (round_num),
    .last_round (last_round),
    .dp_state   (dp_state),
    .dp_key     (dp_key),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES reference datapath ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] w;
    w = {b, b} << k;
    return w[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x; inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) b[rw + 4*c] = a[rw + 4*((c + rw) % 4)];
    for (int c = 0; c < 4; c++) begin
      m[4*c+0] = gmul(b[4*c], 8'h02) ^ gmul(b[4*c+1], 8'h03) ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+1] = b[4*c] ^ gmul(b[4*c+1], 8'h02) ^ gmul(b[4*c+2], 8'h03) ^ b[4*c+3];
      m[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(b[4*c+2], 8'h02) ^ gmul(b[4*c+3], 8'h03);
      m[4*c+3] = gmul(b[4*c], 8'h03) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(b[4*c+3], 8'h02);
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = last ? b[i] : m[i];
    return r ^ k;
  endfunction

  assign dp_key   = kexp(round_key, rcon);
  assign dp_state = aes_round(round_state, dp_key, last_round);

  // ---------------- helpers ----------------
  // NOTE: inputs are driven with blocking assignments 1 time unit after the edge, where outputs are also sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (last_round !== 1'b0) begin n_fail++; $display("FAIL reset_last_round: got %b want 0", last_round); end
    n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_checks++; if (round_key !== 128'h0) begin n_fail++; $display("FAIL reset_round_key: got %h want 0", round_key); end
    n_checks++; if (round_num !== 4'd0) begin n_fail++; $display("FAIL reset_round_num: got %0d want 0", round_num); end
    n_checks++; if (rcon !== 8'h01) begin n_fail++; $display("FAIL reset_rcon: got %h want 01", rcon); end
  endtask

  task automatic test_fips_trace();
    int cyc;
    logic [127:0] exp_init;
    exp_init = PT_A ^ KEY_A;
    out_ready = 1'b1; in_data = PT_A; in_key = KEY_A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (round_state !== exp_init) begin n_fail++; $display("FAIL trace_init_ark: got %h want %h", round_state, exp_init); end
    n_checks++; if (round_key !== KEY_A) begin n_fail++; $display("FAIL trace_init_key: got %h want %h", round_key, KEY_A); end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL trace_busy c%0d: got %b want 1", cyc, busy); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL trace_in_ready c%0d: got %b want 0", cyc, in_ready); end
      n_checks++; if (round_num !== 4'(cyc + 1)) begin n_fail++; $display("FAIL trace_round_num c%0d: got %0d want %0d", cyc, round_num, cyc + 1); end
      n_checks++; if (rcon !== rcon_exp[cyc % NR]) begin n_fail++; $display("FAIL trace_rcon c%0d: got %h want %h", cyc, rcon, rcon_exp[cyc % NR]); end
      n_checks++; if (last_round !== (cyc == NR - 1)) begin n_fail++; $display("FAIL trace_last_round c%0d: got %b want %b", cyc, last_round, cyc == NR - 1); end
      cyc++;
      tick();
    end
    n_checks++; if (cyc !== NR) begin n_fail++; $display("FAIL trace_busy_cycles: got %0d want %0d", cyc, NR); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL trace_out_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data !== CT_A) begin n_fail++; $display("FAIL trace_ciphertext: got %h want %h", out_data, CT_A); end
    n_checks++; if (last_round !== 1'b0) begin n_fail++; $display("FAIL trace_done_last_round: got %b want 0", last_round); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL trace_after_hs_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL trace_after_hs_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0; in_data = PT_A; in_key = KEY_A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid(cyc);
    n_checks++; if (cyc !== NR) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", cyc, NR); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = PT_B; in_key = KEY_B;
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid c%0d: got %b want 1", i, out_valid); end
      n_checks++; if (out_data !== CT_A) begin n_fail++; $display("FAIL bp_out_data c%0d: got %h want %h", i, out_data, CT_A); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
    n_checks++; if (round_state !== CT_A) begin n_fail++; $display("FAIL bp_state_untouched: got %h want %h", round_state, CT_A); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [127:0] exp_init;
    exp_init = PT_B ^ KEY_B;
    out_ready = 1'b1; in_data = PT_A; in_key = KEY_A; in_valid = 1'b1;
    tick();
    in_data = PT_B; in_key = KEY_B;
    wait_out_valid(cyc);
    n_checks++; if (cyc !== NR) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", cyc, NR); end
    n_checks++; if (out_data !== CT_A) begin n_fail++; $display("FAIL b2b_first_ct: got %h want %h", out_data, CT_A); end
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: got %b want 1", busy); end
    n_checks++; if (round_state !== exp_init) begin n_fail++; $display("FAIL b2b_second_ark: got %h want %h", round_state, exp_init); end
    wait_out_valid(cyc);
    n_checks++; if (cyc !== NR) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want %0d", cyc, NR); end
    n_checks++; if (out_data !== CT_B) begin n_fail++; $display("FAIL b2b_second_ct: got %h want %h", out_data, CT_B); end
    tick();
  endtask

  task automatic test_abort();
    int cyc;
    int pulses;
    out_ready = 1'b1; in_data = PT_A; in_key = KEY_A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (round_num !== 4'd5) begin n_fail++; $display("FAIL abort_at_round: got %0d want 5", round_num); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (round_num !== 4'd0) begin n_fail++; $display("FAIL abort_round_num: got %0d want 0", round_num); end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0) pulses++;
      tick();
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_output: got %0d out_valid cycles want 0", pulses); end
    in_valid = 1'b1; abort = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_masks_accept_busy: got %b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_masks_accept_ready: got %b want 1", in_ready); end
    abort = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out_valid(cyc);
    n_checks++; if (cyc !== NR) begin n_fail++; $display("FAIL abort_recover_latency: got %0d want %0d", cyc, NR); end
    n_checks++; if (out_data !== CT_A) begin n_fail++; $display("FAIL abort_recover_ct: got %h want %h", out_data, CT_A); end
    tick();
  endtask

  task automatic test_rst_mid();
    int cyc;
    out_ready = 1'b0; in_data = PT_A; in_key = KEY_A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_checks++; if (round_num !== 4'd3) begin n_fail++; $display("FAIL rst_at_round: got %0d want 3", round_num); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_round_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_round_out_valid: got %b want 0", out_valid); end
    n_checks++; if (round_num !== 4'd0) begin n_fail++; $display("FAIL rst_round_round_num: got %0d want 0", round_num); end
    n_checks++; if (rcon !== 8'h01) begin n_fail++; $display("FAIL rst_round_rcon: got %h want 01", rcon); end
    n_checks++; if (round_state !== 128'h0) begin n_fail++; $display("FAIL rst_round_state: got %h want 0", round_state); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid(cyc);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_reach_done: got %b want 1", out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_done_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_done_in_ready: got %b want 1", in_ready); end
    n_checks++; if (round_num !== 4'd0) begin n_fail++; $display("FAIL rst_done_round_num: got %0d want 0", round_num); end
    n_checks++; if (rcon !== 8'h01) begin n_fail++; $display("FAIL rst_done_rcon: got %h want 01", rcon); end
    n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL rst_done_out_data: got %h want 0", out_data); end
  endtask

  initial begin
    test_reset();
    test_fips_trace();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
